// File: rtl/cpu0_memctl.sv
// cpu0_memctl: handshaked big-endian RAM controller for the cpu0 core, with wait states,
// access-fault reporting and a memory-mapped character FIFO at IO_ADDR.
module cpu0_memctl #(
    parameter int unsigned MEM_BYTES   = 32'h80000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] IO_ADDR     = 32'h80000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        io_valid,
    output logic [7:0]  io_data,
    input  logic        io_ready
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // A word write to the IO port behaves like a C string: output ends at the first zero byte.
    function automatic logic [2:0] word_push_count(input logic [31:0] w);
        logic [2:0] n;
        if (w[7:0] == 8'h00)        n = 3'd0;
        else if (w[15:8] == 8'h00)  n = 3'd1;
        else if (w[23:16] == 8'h00) n = 3'd2;
        else if (w[31:24] == 8'h00) n = 3'd3;
        else                        n = 3'd4;
        return n;
    endfunction

    logic [1:0]    state_r;
    logic          ready_r;
    logic          rsp_valid_r;
    logic          rsp_err_r;
    logic [31:0]   rsp_rdata_r;
    logic [3:0]    cnt_r;
    logic          rw_r;
    logic [1:0]    size_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;

    logic [7:0]    ram_r [MEM_BYTES];
    logic [7:0]    fifo_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic [2:0]    nbytes_s;
    logic [32:0]   end_s;
    logic          is_io_s;
    logic          err_s;
    logic [2:0]    push_n_s;
    logic [2:0]    push_now_s;
    logic          pop_s;
    logic [CW:0]   free_s;
    logic          commit_s;
    logic [31:0]   wr_al_s;
    logic [31:0]   rd_data_s;
    logic [7:0]    b0_s, b1_s, b2_s, b3_s;

    // Decode of the latched request: faults, FIFO demand and the commit condition.
    always_comb begin
        nbytes_s = {1'b0, size_r} + 3'd1;
        end_s    = {1'b0, addr_r} + {30'd0, nbytes_s};
        is_io_s  = (addr_r == IO_ADDR);
        if (size_r == 2'b01 && addr_r[0])                          err_s = 1'b1;
        else if (size_r == 2'b11 && addr_r[1:0] != 2'b00)          err_s = 1'b1;
        else if (!is_io_s && end_s > 33'(MEM_BYTES))               err_s = 1'b1;
        else if (is_io_s && (size_r == 2'b01 || size_r == 2'b10))  err_s = 1'b1;
        else                                                       err_s = 1'b0;
        if (is_io_s && !rw_r && !err_s) begin
            if (size_r == 2'b00) push_n_s = 3'd1;
            else                 push_n_s = word_push_count(wdata_r);
        end else begin
            push_n_s = 3'd0;
        end
        pop_s    = (count_r != CW'(0)) && io_ready;
        // A pop landing on the commit edge frees its slot for this commit.
        free_s   = (CW+1)'(FIFO_DEPTH) - {1'b0, count_r} + {{CW{1'b0}}, pop_s};
        commit_s = (state_r == ST_WAIT) && (cnt_r == 4'd0) && (free_s >= (CW+1)'(push_n_s));
        if (commit_s) push_now_s = push_n_s;
        else          push_now_s = 3'd0;
        wr_al_s  = wdata_r << {(3'd4 - nbytes_s), 3'b000};
    end

    // Big-endian read assembly; IO reads return the FIFO free/used counts.
    always_comb begin
        b0_s = ram_r[AW'(addr_r)];
        b1_s = ram_r[AW'(addr_r + 32'd1)];
        b2_s = ram_r[AW'(addr_r + 32'd2)];
        b3_s = ram_r[AW'(addr_r + 32'd3)];
        if (err_s || !rw_r) begin
            rd_data_s = 32'd0;
        end else if (is_io_s) begin
            rd_data_s = {16'h0000, 8'(32'(FIFO_DEPTH) - 32'(count_r)), 8'(count_r)};
        end else begin
            case (size_r)
                2'b00:   rd_data_s = {24'd0, b0_s};
                2'b01:   rd_data_s = {16'd0, b0_s, b1_s};
                2'b10:   rd_data_s = {8'd0, b0_s, b1_s, b2_s};
                2'b11:   rd_data_s = {b0_s, b1_s, b2_s, b3_s};
                default: rd_data_s = 32'd0;
            endcase
        end
    end

    // Request FSM, latched request and registered response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
            cnt_r       <= 4'd0;
            rw_r        <= 1'b0;
            size_r      <= 2'b00;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (req_valid && ready_r) begin
                        state_r <= ST_WAIT;
                        ready_r <= 1'b0;
                        cnt_r   <= 4'(WAIT_STATES);
                        rw_r    <= req_rw;
                        size_r  <= req_size;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (commit_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= rd_data_s;
                        rsp_err_r   <= err_s;
                    end else if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    ready_r     <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    ready_r     <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port: only a committed, fault-free, non-IO write reaches the array.
    always_ff @(posedge clock) begin
        if (commit_s && !rw_r && !err_s && !is_io_s) begin
            ram_r[AW'(addr_r)] <= wr_al_s[31:24];
            if (nbytes_s > 3'd1) ram_r[AW'(addr_r + 32'd1)] <= wr_al_s[23:16];
            if (nbytes_s > 3'd2) ram_r[AW'(addr_r + 32'd2)] <= wr_al_s[15:8];
            if (nbytes_s > 3'd3) ram_r[AW'(addr_r + 32'd3)] <= wr_al_s[7:0];
        end
    end

    // FIFO storage: all bytes of one commit land on the same edge.
    always_ff @(posedge clock) begin
        if (push_now_s > 3'd0) fifo_r[wr_ptr_r]           <= wdata_r[7:0];
        if (push_now_s > 3'd1) fifo_r[wr_ptr_r + PW'(1)]  <= wdata_r[15:8];
        if (push_now_s > 3'd2) fifo_r[wr_ptr_r + PW'(2)]  <= wdata_r[23:16];
        if (push_now_s > 3'd3) fifo_r[wr_ptr_r + PW'(3)]  <= wdata_r[31:24];
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            wr_ptr_r <= wr_ptr_r + PW'(push_now_s);
            if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            count_r  <= count_r + CW'(push_now_s) - CW'(pop_s);
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign io_valid  = (count_r != CW'(0));
    assign io_data   = io_valid ? fifo_r[rd_ptr_r] : 8'h00;

endmodule

// File: tb/tb_cpu0_memctl.sv
// Directed bench for cpu0_memctl: one instance with one wait state for access and FIFO
// behaviour, and one with zero wait states for back-to-back handshake timing.
`timescale 1ns/1ps
module tb_cpu0_memctl;
    localparam logic [31:0] IO = 32'h0008_0000;

    logic        clock = 1'b0;
    logic        reset, req_valid, req_ready, req_rw, rsp_valid, rsp_err, io_valid, io_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [7:0]  io_data;
    logic        reset0, req_valid0, req_ready0, rsp_valid0, rsp_err0, io_valid0;
    logic [31:0] rsp_rdata0;
    logic [7:0]  io_data0;
    int          n_vec = 0;
    int          n_err = 0;
    int          seen;

    always #5 clock = ~clock;

    cpu0_memctl #(.MEM_BYTES(32'h80000), .WAIT_STATES(1), .IO_ADDR(IO), .FIFO_DEPTH(8)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .io_valid(io_valid), .io_data(io_data), .io_ready(io_ready));

    cpu0_memctl #(.MEM_BYTES(32'h80000), .WAIT_STATES(0), .IO_ADDR(IO), .FIFO_DEPTH(8)) u_dut0 (
        .clock(clock), .reset(reset0), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_rw(1'b1), .req_size(2'b00), .req_addr(IO), .req_wdata(32'd0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .io_valid(io_valid0), .io_data(io_data0), .io_ready(1'b0));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered on a negedge; returns on the negedge after the accepting edge.
    task automatic start_req(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
        int k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (!req_ready) check_eq("ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_rw = rw; req_size = sz; req_addr = a; req_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        if (!rsp_valid) check_eq("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic req_chk(input string tag, input logic rw, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        logic [31:0] rd;
        logic er;
        start_req(rw, sz, a, wd);
        wait_rsp(lat, rd, er);
        check_eq({tag, "_lat"}, 32'(lat), 32'd3);
        check_eq({tag, "_rdata"}, rd, exp_rd);
        check_eq({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic drain(input logic [7:0] e);
        check_eq("drain_data", {24'd0, io_data}, {24'd0, e});
        io_ready = 1'b1;
        @(negedge clock);
        io_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; reset0 = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; io_ready = 1'b0;
        req_rw = 1'b0; req_size = 2'b00; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clock);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_io_valid", {31'd0, io_valid}, 32'd0);
        check_eq("rst_io_data", {24'd0, io_data}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Basic big-endian accesses and faults
        req_chk("wr_w100", 1'b0, 2'b11, 32'h100, 32'h11223344, 32'd0, 1'b0);
        @(negedge clock);
        check_eq("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        req_chk("rd_b101",   1'b1, 2'b00, 32'h101,   32'd0,        32'h22,     1'b0);
        req_chk("rd_h102",   1'b1, 2'b01, 32'h102,   32'd0,        32'h3344,   1'b0);
        req_chk("rd_t101",   1'b1, 2'b10, 32'h101,   32'd0,        32'h223344, 1'b0);
        req_chk("rd_w102",   1'b1, 2'b11, 32'h102,   32'd0,        32'd0,      1'b1);
        req_chk("wr_b7fffe", 1'b0, 2'b00, 32'h7FFFE, 32'h5A,       32'd0,      1'b0);
        req_chk("wr_w7fffe", 1'b0, 2'b11, 32'h7FFFE, 32'hCAFEBABE, 32'd0,      1'b1);
        req_chk("rd_t7fffe", 1'b1, 2'b10, 32'h7FFFE, 32'd0,        32'd0,      1'b1);
        req_chk("rd_h7ffff", 1'b1, 2'b01, 32'h7FFFF, 32'd0,        32'd0,      1'b1);
        req_chk("rd_b7fffe", 1'b1, 2'b00, 32'h7FFFE, 32'd0,        32'h5A,     1'b0);

        // IO port: string pushes, status reads, illegal sizes
        req_chk("io_wr_abc", 1'b0, 2'b11, IO, 32'h00434241, 32'd0, 1'b0);
        check_eq("io_valid_abc", {31'd0, io_valid}, 32'd1);
        check_eq("io_head_abc", {24'd0, io_data}, 32'h41);
        req_chk("io_wr_d",    1'b0, 2'b11, IO, 32'h44000000, 32'd0,     1'b0);
        req_chk("io_wr_nul",  1'b0, 2'b00, IO, 32'd0,        32'd0,     1'b0);
        req_chk("io_rd_stat", 1'b1, 2'b11, IO, 32'd0,        32'h0404,  1'b0);
        req_chk("io_rd_byte", 1'b1, 2'b00, IO, 32'd0,        32'h0404,  1'b0);
        req_chk("io_half",    1'b1, 2'b01, IO, 32'd0,        32'd0,     1'b1);
        drain(8'h41); drain(8'h42); drain(8'h43); drain(8'h00);
        check_eq("io_empty", {31'd0, io_valid}, 32'd0);

        // Fill the FIFO, then a ninth push must stall until a pop frees a slot
        for (int i = 0; i < 8; i++) req_chk("fill", 1'b0, 2'b00, IO, 32'h61 + 32'(i), 32'd0, 1'b0);
        req_chk("io_full_stat", 1'b1, 2'b11, IO, 32'd0, 32'h0008, 1'b0);
        start_req(1'b0, 2'b00, IO, 32'h7A);
        seen = 0;
        repeat (6) begin
            if (rsp_valid) seen++;
            @(negedge clock);
        end
        check_eq("stall_no_rsp", 32'(seen), 32'd0);
        io_ready = 1'b1;
        @(negedge clock);
        io_ready = 1'b0;
        check_eq("stall_rsp", {31'd0, rsp_valid}, 32'd1);
        check_eq("stall_err", {31'd0, rsp_err}, 32'd0);
        for (int i = 0; i < 7; i++) drain(8'h62 + 8'(i));
        drain(8'h7A);
        check_eq("io_empty2", {31'd0, io_valid}, 32'd0);

        // Reset in the middle of a write must abort it
        req_chk("wr_w200", 1'b0, 2'b11, 32'h200, 32'hCAFEF00D, 32'd0, 1'b0);
        req_chk("io_wr_u", 1'b0, 2'b00, IO,      32'h55,       32'd0, 1'b0);
        req_chk("rd_w200", 1'b1, 2'b11, 32'h200, 32'd0,        32'hCAFEF00D, 1'b0);
        start_req(1'b0, 2'b11, 32'h200, 32'hDEADBEEF);
        reset = 1'b0;
        #1;
        check_eq("abort_ready", {31'd0, req_ready}, 32'd0);
        check_eq("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("abort_rdata", rsp_rdata, 32'd0);
        check_eq("abort_err", {31'd0, rsp_err}, 32'd0);
        check_eq("abort_io_valid", {31'd0, io_valid}, 32'd0);
        check_eq("abort_io_data", {24'd0, io_data}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        req_chk("rd_w200_post", 1'b1, 2'b11, 32'h200, 32'd0, 32'hCAFEF00D, 1'b0);

        // Zero wait states, req_valid held: accept every third cycle
        req_valid0 = 1'b1;
        @(negedge clock);
        reset0 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            check_eq("b2b_ready", {31'd0, req_ready0}, {31'd0, (k % 3) == 0});
            check_eq("b2b_rsp", {31'd0, rsp_valid0}, {31'd0, (k % 3) == 2});
            if (rsp_valid0) check_eq("b2b_rdata", rsp_rdata0, 32'h0800);
        end
        check_eq("b2b_io_valid", {31'd0, io_valid0}, 32'd0);
        check_eq("b2b_io_data", {24'd0, io_data0}, 32'd0);
        check_eq("b2b_err", {31'd0, rsp_err0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
